// File: rtl/gate_pkg.sv
// Shared definitions for the time-shared mux gate scheduler:
// opcode encodings and FSM state encoding.
package gate_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_NOT = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL1 = 2'd1,
        EVAL2 = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/gate_mux2.sv
// Shared 2:1 mux primitive; every logic function of the scheduler is
// built by steering operands and constants through this one instance.
module gate_mux2 (
    input  logic sel,
    input  logic in0,
    input  logic in1,
    output logic z
);

    assign z = sel ? in1 : in0;

endmodule

// File: rtl/mux_gate_scheduler.sv
// Round-robin scheduler time-sharing one gate_mux2 among NREQ requesters.
// Optional feature macro: MUX_GATE_XOR_EN (two-pass XOR for opcode 11;
// without it opcode 11 answers with rsp_err=1 and rsp_z=0).
module mux_gate_scheduler
    import gate_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [2*NREQ-1:0] op,
    input  logic [NREQ-1:0]   a,
    input  logic [NREQ-1:0]   b,
    output logic [NREQ-1:0]   gnt,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic              rsp_z,
    output logic              rsp_err
);

    state_t            state_r, state_s;
    logic [IDW-1:0]    rr_ptr_r, rr_ptr_s;
    logic [IDW-1:0]    win_s;
    logic              win_vld_s;
    logic [1:0]        op_r, op_s;
    logic              a_r, a_s, b_r, b_s;
`ifdef MUX_GATE_XOR_EN
    logic              nb_r, nb_s;
`endif
    logic [NREQ-1:0]   gnt_s;
    logic              rsp_valid_s, rsp_z_s, rsp_err_s;
    logic [IDW-1:0]    rsp_id_s;
    logic              mux_sel_s, mux_in0_s, mux_in1_s, mux_z_s;

    gate_mux2 u_mux (
        .sel (mux_sel_s),
        .in0 (mux_in0_s),
        .in1 (mux_in1_s),
        .z   (mux_z_s)
    );

    // Round-robin search: first set req bit at or after rr_ptr, with wrap.
    always_comb begin
        win_vld_s = 1'b0;
        win_s     = {IDW{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            if (!win_vld_s && req[(int'(rr_ptr_r) + i) % NREQ]) begin
                win_vld_s = 1'b1;
                win_s     = IDW'((int'(rr_ptr_r) + i) % NREQ);
            end else begin
                win_vld_s = win_vld_s;
                win_s     = win_s;
            end
        end
    end

    // Steer latched operands and constants onto the shared mux for the current pass.
    always_comb begin
        mux_sel_s = 1'b0;
        mux_in0_s = 1'b0;
        mux_in1_s = 1'b0;
        case (state_r)
            EVAL1: begin
                case (op_r)
                    OP_AND: begin mux_sel_s = a_r; mux_in1_s = b_r;  mux_in0_s = 1'b0; end
                    OP_OR:  begin mux_sel_s = a_r; mux_in1_s = 1'b1; mux_in0_s = b_r;  end
                    OP_NOT: begin mux_sel_s = a_r; mux_in1_s = 1'b0; mux_in0_s = 1'b1; end
`ifdef MUX_GATE_XOR_EN
                    OP_XOR: begin mux_sel_s = b_r; mux_in1_s = 1'b0; mux_in0_s = 1'b1; end
`endif
                    default: begin mux_sel_s = 1'b0; mux_in1_s = 1'b0; mux_in0_s = 1'b0; end
                endcase
            end
`ifdef MUX_GATE_XOR_EN
            EVAL2: begin mux_sel_s = a_r; mux_in1_s = nb_r; mux_in0_s = b_r; end
`endif
            default: begin mux_sel_s = 1'b0; mux_in1_s = 1'b0; mux_in0_s = 1'b0; end
        endcase
    end

    // Next-state, next-output and operand-capture decisions.
    always_comb begin
        state_s     = state_r;
        rr_ptr_s    = rr_ptr_r;
        op_s        = op_r;
        a_s         = a_r;
        b_s         = b_r;
`ifdef MUX_GATE_XOR_EN
        nb_s        = nb_r;
`endif
        gnt_s       = {NREQ{1'b0}};
        rsp_valid_s = 1'b0;
        rsp_id_s    = rsp_id;
        rsp_z_s     = rsp_z;
        rsp_err_s   = rsp_err;
        case (state_r)
            IDLE: begin
                if (win_vld_s) begin
                    op_s     = op[2*int'(win_s) +: 2];
                    a_s      = a[win_s];
                    b_s      = b[win_s];
                    gnt_s    = {{(NREQ-1){1'b0}}, 1'b1} << win_s;
                    rsp_id_s = win_s;
                    rr_ptr_s = (int'(win_s) == NREQ - 1) ? {IDW{1'b0}} : win_s + IDW'(1);
                    state_s  = EVAL1;
                end else begin
                    state_s  = IDLE;
                end
            end
            EVAL1: begin
                case (op_r)
                    OP_AND, OP_OR, OP_NOT: begin
                        rsp_z_s     = mux_z_s;
                        rsp_err_s   = 1'b0;
                        rsp_valid_s = 1'b1;
                        state_s     = RESP;
                    end
`ifdef MUX_GATE_XOR_EN
                    OP_XOR: begin
                        nb_s    = mux_z_s;
                        state_s = EVAL2;
                    end
`endif
                    default: begin
                        // Unsupported opcode: answer with an error flag and a zero result.
                        rsp_z_s     = 1'b0;
                        rsp_err_s   = 1'b1;
                        rsp_valid_s = 1'b1;
                        state_s     = RESP;
                    end
                endcase
            end
`ifdef MUX_GATE_XOR_EN
            EVAL2: begin
                rsp_z_s     = mux_z_s;
                rsp_err_s   = 1'b0;
                rsp_valid_s = 1'b1;
                state_s     = RESP;
            end
`endif
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Arbitration pointer, captured operands and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r  <= {IDW{1'b0}};
            op_r      <= 2'b00;
            a_r       <= 1'b0;
            b_r       <= 1'b0;
`ifdef MUX_GATE_XOR_EN
            nb_r      <= 1'b0;
`endif
            gnt       <= {NREQ{1'b0}};
            rsp_valid <= 1'b0;
            rsp_id    <= {IDW{1'b0}};
            rsp_z     <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            rr_ptr_r  <= rr_ptr_s;
            op_r      <= op_s;
            a_r       <= a_s;
            b_r       <= b_s;
`ifdef MUX_GATE_XOR_EN
            nb_r      <= nb_s;
`endif
            gnt       <= gnt_s;
            rsp_valid <= rsp_valid_s;
            rsp_id    <= rsp_id_s;
            rsp_z     <= rsp_z_s;
            rsp_err   <= rsp_err_s;
        end
    end

endmodule

// File: tb/tb_mux_gate_scheduler.sv
// Scoreboard bench for mux_gate_scheduler: a cycle-level reference model
// predicts grants and responses, a negedge monitor pops and compares them.
module tb_mux_gate_scheduler;

    localparam int NREQ = 2;
    localparam int IDW  = 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [2*NREQ-1:0] op  = '0;
    logic [NREQ-1:0]   a   = '0;
    logic [NREQ-1:0]   b   = '0;
    logic [NREQ-1:0]   gnt;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_z;
    logic              rsp_err;

    mux_gate_scheduler #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .a(a), .b(b),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_z(rsp_z), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; int mask; } gnt_t;
    typedef struct { int cyc; int id; int z; int err; } rsp_t;

    gnt_t gq[$];
    rsp_t rq[$];
    gnt_t mon_g;
    rsp_t mon_r;
    int   cyc    = 0;
    int   m_busy = 0;
    int   m_rr   = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Round-robin pick: first set bit at or after rr, with wrap.
    function automatic int pick(input logic [NREQ-1:0] r, input int rr);
        for (int i = 0; i < NREQ; i++) begin
            if (r[(rr + i) % NREQ]) return (rr + i) % NREQ;
        end
        return -1;
    endfunction

    // Result, error flag and total occupancy (cycles) of one operation.
    function automatic rsp_t outcome(input logic [1:0] o, input logic x, input logic y);
        rsp_t r;
        r.cyc = 3; r.err = 0; r.id = 0;
        case (o)
            2'd0: r.z = int'(x & y);
            2'd1: r.z = int'(x | y);
            2'd2: r.z = int'(!x);
            default: begin
`ifdef MUX_GATE_XOR_EN
                r.z = int'(x ^ y); r.cyc = 4;
`else
                r.z = 0; r.err = 1;
`endif
            end
        endcase
        return r;
    endfunction

    function automatic gnt_t mk_gnt(input int w, input int k);
        gnt_t g;
        g.cyc = k; g.mask = 1 << w;
        return g;
    endfunction

    function automatic rsp_t mk_rsp(input int w, input logic [1:0] o, input logic x, input logic y, input int k);
        rsp_t r;
        r = outcome(o, x, y);
        r.id  = w;
        r.cyc = k + r.cyc - 2;
        return r;
    endfunction

    // Reference model: one decision per rising edge (cycle k = value of cyc after the edge).
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_busy <= 0;
            m_rr   <= 0;
            rq.delete();
        end else if (m_busy > 0) begin
            m_busy <= m_busy - 1;
        end else if (req != '0) begin
            gq.push_back(mk_gnt(pick(req, m_rr), cyc + 1));
            rq.push_back(mk_rsp(pick(req, m_rr), op[2*pick(req, m_rr) +: 2],
                                a[pick(req, m_rr)], b[pick(req, m_rr)], cyc + 1));
            m_busy <= outcome(op[2*pick(req, m_rr) +: 2], 1'b0, 1'b0).cyc - 1;
            m_rr   <= (pick(req, m_rr) + 1) % NREQ;
        end
    end

    // Monitor: compare every presented grant/response against the scoreboard.
    always @(negedge clk) begin
        if (gq.size() > 0 && gq[0].cyc < cyc) begin
            mon_g = gq.pop_front();
            check("gnt_missing", 0, mon_g.mask);
        end
        if (rq.size() > 0 && rq[0].cyc < cyc) begin
            mon_r = rq.pop_front();
            check("rsp_missing", 0, 1);
        end
        if (gnt != '0) begin
            if (gq.size() == 0) begin
                check("gnt_unexpected", int'(gnt), 0);
            end else begin
                mon_g = gq.pop_front();
                check("gnt_cycle", cyc, mon_g.cyc);
                check("gnt_mask", int'(gnt), mon_g.mask);
            end
        end
        if (rsp_valid === 1'b1) begin
            if (rq.size() == 0) begin
                check("rsp_unexpected", 1, 0);
            end else begin
                mon_r = rq.pop_front();
                check("rsp_cycle", cyc, mon_r.cyc);
                check("rsp_id", int'(rsp_id), mon_r.id);
                check("rsp_z", int'(rsp_z), mon_r.z);
                check("rsp_err", int'(rsp_err), mon_r.err);
            end
        end
    end

    task automatic wait_gnt(input int idx);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!gnt[idx] && n < 12);
        if (!gnt[idx]) check("gnt_timeout", 0, 1);
    endtask

    task automatic do_op(input int idx, input logic [1:0] o, input logic x, input logic y);
        @(negedge clk);
        op[2*idx +: 2] = o;
        a[idx] = x;
        b[idx] = y;
        req[idx] = 1'b1;
        wait_gnt(idx);
        req[idx] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_gnt"}, int'(gnt), 0);
        check({tag, "_rsp_valid"}, int'(rsp_valid), 0);
        check({tag, "_rsp_id"}, int'(rsp_id), 0);
        check({tag, "_rsp_z"}, int'(rsp_z), 0);
        check({tag, "_rsp_err"}, int'(rsp_err), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        // Directed OR with a=0, b=1.
        do_op(0, 2'b01, 1'b0, 1'b1);

        // Sweep of AND/OR/NOT over all operand pairs on both requesters.
        for (int o = 0; o < 3; o++) begin
            for (int v = 0; v < 4; v++) begin
                do_op(v % 2, 2'(o), v[1], v[0]);
            end
        end

        // Both requesters held with AND 1,1: alternating grants 3 cycles apart.
        @(negedge clk);
        op = 4'b0000; a = 2'b11; b = 2'b11; req = 2'b11;
        repeat (14) @(negedge clk);
        req = 2'b00;
        repeat (5) @(negedge clk);

        // XOR 1^0 then 1^1.
        do_op(0, 2'b11, 1'b1, 1'b0);
        do_op(1, 2'b11, 1'b1, 1'b1);

        // Reset while requester 0's operation is in its first pass.
        @(negedge clk);
        op[1:0] = 2'b00; a[0] = 1'b1; b[0] = 1'b1; req = 2'b01;
        wait_gnt(0);
        rst = 1'b1;
        req = 2'b00;
        @(negedge clk);
        check_idle_outputs("midop_reset");
        rst = 1'b0;
        op = 4'b0000; a = 2'b11; b = 2'b11; req = 2'b11;
        @(negedge clk);
        check("post_reset_first_gnt", int'(gnt), 1);
        req = 2'b00;
        repeat (6) @(negedge clk);

        // Randomized traffic with occasional reset pulses.
        for (int t = 0; t < 600; t++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (req[i]) begin
                    if (gnt[i] && $urandom_range(0, 1) == 1) req[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    op[2*i +: 2] = 2'($urandom_range(0, 3));
                    a[i] = 1'($urandom_range(0, 1));
                    b[i] = 1'($urandom_range(0, 1));
                    req[i] = 1'b1;
                end
            end
        end
        rst = 1'b0;
        req = '0;
        repeat (8) @(negedge clk);
        check("drain_gnt_queue", gq.size(), 0);
        check("drain_rsp_queue", rq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_gate_scheduler.md
Name: mux_gate_scheduler

Overview:
- Time-shares one 2:1 mux-based logic unit (AND/OR/NOT, optional XOR) among NREQ requesters.
- Round-robin arbitration; captures the winner's operands, sequences one or two mux passes, returns a tagged single-bit result.
- Sits between the gate-exercising clients and the shared mux primitive. Replaces per-client gate instances.

Parameters:
- NREQ, 2, number of requesters (2..8).
- IDW, 1, width of rsp_id; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request level.
- op  in  2*NREQ  opcode of requester i at [2i+1:2i]: 00 AND, 01 OR, 10 NOT A, 11 XOR.
- a  in  NREQ  operand A of requester i at bit i.
- b  in  NREQ  operand B of requester i at bit i.
- gnt  out  NREQ  one-hot, one-cycle pulse: operands of requester i captured.
- rsp_valid  out  1  one-cycle pulse, result available.
- rsp_id  out  IDW  index of the requester being answered.
- rsp_z  out  1  result bit.
- rsp_err  out  1  high with rsp_valid when the opcode is unsupported.

Behaviour:
- Reset values: gnt=0, rsp_valid=0, rsp_id=0, rsp_z=0, rsp_err=0, state=IDLE, rr_ptr=0. All outputs are registered.
- Reset is synchronous and takes priority over everything. Asserting rst mid-operation discards the captured op, emits no response, and returns to IDLE on the next edge.
- FSM states: IDLE, EVAL1, EVAL2, RESP.
- IDLE:
  - req is sampled only in IDLE.
  - If any req bit is set, the winner is the first set bit at or after rr_ptr, searching upward with wrap.
  - The winner's op, a and b are latched. gnt[winner]=1 and rsp_id=winner are registered. State goes to EVAL1.
  - rr_ptr becomes winner+1, wrapping to 0 after NREQ-1.
- EVAL1 (gnt high this cycle):
  - One mux pass: Z = sel ? in1 : in0.
  - AND: sel=A, in1=B, in0=0.
  - OR: sel=A, in1=1, in0=B.
  - NOT: sel=A, in1=0, in0=1.
  - Result goes to rsp_z; state goes to RESP.
  - XOR: pass 1 computes nb = B ? 0 : 1 into a temp register; state goes to EVAL2.
- EVAL2: pass 2 computes Z = A ? nb : B; state goes to RESP.
- RESP: rsp_valid=1 for exactly this cycle, then IDLE.
- Latency from the edge that samples req in IDLE:
  - gnt is high during cycle +1.
  - rsp_valid is high during cycle +2 (single-pass ops) or +3 (XOR).
- Throughput: one op per 3 cycles, or 4 cycles for XOR.
- Requester protocol:
  - op, a and b must be stable while req is high and until gnt.
  - A req still high when the FSM is next in IDLE counts as a new request.
  - Requesters ignore rsp_valid whose rsp_id is not their own.
- req changes while the FSM is not in IDLE have no effect.

Optional Feature:
- Macro: MUX_GATE_XOR_EN.
- Defined: op 11 executes the two-pass XOR above; rsp_err=0.
- Undefined:
  - EVAL2 is not implemented.
  - op 11 goes EVAL1 -> RESP with rsp_z=0 and rsp_err=1. Latency equals single-pass ops.

Decomposition:
- Package gate_pkg holds:
  - opcode localparams OP_AND, OP_OR, OP_NOT, OP_XOR.
  - state encoding IDLE/EVAL1/EVAL2/RESP.
- Sub-module gate_mux2 is the shared combinational primitive (sel, in0, in1 -> z). It is instantiated exactly once; all passes are steered through it.

Test Plan:
- Reset, then req=01, op0=01 (OR), a0=0, b0=1: gnt=01 at +1; rsp_valid, rsp_id=0, rsp_z=1, rsp_err=0 at +2.
- Exhaustive single-requester sweep of AND/OR/NOT over a,b ∈ {00,01,10,11}:
  - AND gives 0,0,0,1; OR gives 0,1,1,1; NOT A gives 1,1,0,0.
  - One pulse per op.
- req=11 held continuously, both AND with a=b=1: grants alternate 01,10,01,10, rsp_id alternates 0,1,0,1, every rsp_z=1, exactly 3 cycles apart.
- XOR with a=1, b=0, then a=1, b=1:
  - MUX_GATE_XOR_EN defined: rsp_z=1 then 0, each at +3.
  - Undefined: rsp_err=1, rsp_z=0 at +2.
- rst asserted during EVAL1 of a granted request: no rsp_valid that op; all outputs 0 next cycle; next grant with req=11 goes to requester 0.
